// File: rtl/counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with asynchronous active-low clear.
// Latency: one clock per step; no flow control, it never stalls.
module counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] count;

  // The clear goes straight to the flop; release timing belongs to the reset network.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == MAX_COUNT) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign value = count;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default 8-bit instance and a WIDTH=4, MAX_COUNT=9 instance
// sharing one clock and reset.
module tb_counter;

  logic       clk;
  logic       reset;
  logic [7:0] v8;
  logic [3:0] v4;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  counter u_cnt8 (
    .value(v8),
    .clk  (clk),
    .reset(reset)
  );

  counter #(
    .WIDTH    (4),
    .MAX_COUNT(4'd9)
  ) u_cnt4 (
    .value(v4),
    .clk  (clk),
    .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_8"}, {24'd0, v8}, 32'd0);
    check({tag, "_4"}, {28'd0, v4}, 32'd0);
  endtask

  // One clock step sampled on the falling edge; n counts edges since reset release.
  task automatic step(input string tag);
    @(negedge clk);
    n++;
    check({tag, "_8"}, {24'd0, v8}, n % 256);
    check({tag, "_4"}, {28'd0, v4}, n % 10);
    check({tag, "_le9"}, {31'd0, (v4 <= 4'd9)}, 32'd1);
  endtask

  initial begin
    // Power-up: force a genuine falling edge on reset so the async clear fires.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_zero("por");
    repeat (2) begin
      @(negedge clk);
      check_zero("por_hold");
    end

    reset = 1'b1;
    n = 0;
    repeat (10) step("run");

    // Short pulse between edges clears immediately, before any clock.
    #2 reset = 1'b0;
    #1 check_zero("pulse");
    #1 reset = 1'b1;
    n = 0;
    repeat (3) step("after_pulse");

    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      check_zero("held");
    end
    reset = 1'b1;
    step("held_rel");

    // Release lands on the same edge the counter samples: NBA keeps it behind that edge.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    reset <= 1'b1;
    n = 0;
    @(negedge clk);
    check_zero("coinc");
    step("coinc_next");

    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
    n = 0;
    repeat (257) step("wrap");
    check("wrap_end8", {24'd0, v8}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter.md
# counter

Free-running up-counter with asynchronous clear, used as a basic timebase and event-sequencing source in the design. It presents its current count on a parallel output bus, advances by one on every rising clock edge, and wraps to zero after reaching its terminal value. Typical uses are cycle counting, simple dividers (tap a bit of `value`), and bring-up visibility of clock and reset health.

## Interface
- `WIDTH`, default 8: count and output width in bits; legal range 1–32.
- `MAX_COUNT`, default 2**WIDTH-1: terminal count; the next increment returns to 0. Legal range 1 to 2**WIDTH-1.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. While low, the count is forced to 0.
- `value`  output  WIDTH  current count, driven directly from the count register.
- Positional port order for instantiation is `value`, `clk`, `reset`.

## Operation
- State is a single WIDTH-bit register `count`, and `value` = `count` at all times.
- Reset behaviour:
  - `reset` low clears `count` to 0 immediately, with no clock required.
  - `count` holds at 0 for as long as `reset` stays low, and clock edges are ignored.
- Counting behaviour, when `reset` is high, on each rising edge of `clk`:
  - if `count` == MAX_COUNT, then `count` <= 0;
  - otherwise `count` <= `count` + 1.
- Arithmetic is unsigned modulo (MAX_COUNT+1). No value above MAX_COUNT is ever produced.
  - If MAX_COUNT = 2**WIDTH-1, this is natural binary wrap.
- There are no enable, load or direction controls. The counter always runs when out of reset.
- Before the first reset assertion, `count` is undefined (X in simulation). The system must assert reset at power-up.
- Reset asserted mid-count, at any value including MAX_COUNT, returns the count to 0. No partial state is retained.
- The reset path drives the register's async clear directly, with no internal synchronizer. Meeting reset-release recovery/removal timing is the responsibility of the reset distribution network.

## Timing
- Increment latency: one clock. `value` updates on the rising edge, plus clock-to-Q delay.
- Reset assertion: `value` goes to 0 asynchronously, within the clear-to-Q delay, independent of `clk`.
- Reset release:
  - The first increment occurs on the first rising edge of `clk` at which `reset` is already high.
  - That edge produces `value` = 1.
  - A rising clock edge coincident with the reset release edge is treated as still in reset, so `value` stays 0.
- At steady state, `value` runs 0,1,2,…,MAX_COUNT,0,… with exactly one step per clock period.
- Reset pulses shorter than one clock period are honoured, since the clear is asynchronous.
- Multiple reset pulses are each handled independently; there is no one-shot behaviour.
- Output is glitch-free between edges because it is driven straight from the register, with no combinational decode.

## Test plan
- Power-up and release: `reset` low at t=0, release high, then 10 rising edges → `value` reads 0 during reset, then 1,2,…,10 on successive edges.
- Mid-count reset: count to 3, pulse `reset` low for less than one clock period between edges → `value` drops to 0 immediately (before the next edge), then resumes at 1,2,3….
- Reset held across clocks: hold `reset` low for 5 clock periods → `value` stays 0 on every edge; first edge after release gives 1.
- Wrap, default parameters: run 256 edges after reset → sequence reaches 255 (0xFF), then 0 on the next edge, then 1.
- Custom terminal count: WIDTH=4, MAX_COUNT=9, run 12 edges after reset → 1…9, 0, 1, 2; `value` never exceeds 9.
- Coincident edge: release `reset` on a rising `clk` edge → `value` remains 0 at that edge and becomes 1 on the following edge.
